// File: rtl/matmul_seq_core_pkg.sv
// Shared types and width helpers for the sequential NxN matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    // Result width: a W x W product plus enough headroom for N-term accumulation.
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    // Counter width able to hold 0..n-1.
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_seq_core_if.sv
// Element stream in (A then B, row-major) and result stream out (C, row-major).
interface matmul_seq_core_if #(
    parameter int N = 2,
    parameter int W = 2,
    localparam int ACC_W = matmul_pkg::acc_width(N, W)
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/matmul_mac.sv
// Single multiply-accumulate unit time-shared across all C elements.
module matmul_mac import matmul_pkg::*; #(
    parameter int N = 2,
    parameter int W = 2,
    localparam int ACC_W = acc_width(N, W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             clr,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] acc
);

    logic [2*W-1:0] prod;

    assign prod = (2*W)'(a) * (2*W)'(b);

    // One product per enabled cycle; clr starts a fresh sum with this product.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (ena) begin
            acc <= (clr ? '0 : acc) + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/matmul_seq_core.sv
// NxN unsigned matrix multiplier: stream A/B in, one MAC per cycle, stream C out.
module matmul_seq_core import matmul_pkg::*; #(
    parameter int N       = 2,
    parameter int W       = 2,
    parameter int MAX_VAL = 2,
    localparam int ACC_W  = acc_width(N, W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    matmul_seq_core_if.slave  bus,
    output logic              busy,
    output logic              error
);

    localparam int          IW    = idx_w(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam int unsigned MAX_U = MAX_VAL;

    state_t state_q, state_d;

    logic [W-1:0]     a_mem [N][N];
    logic [W-1:0]     b_mem [N][N];
    logic [ACC_W-1:0] c_mem [N][N];

    logic [IW-1:0]    ld_r, ld_c;
    logic             ld_b;
    logic [IW-1:0]    ci, cj, ck;
    logic [IW-1:0]    wr_i, wr_j;
    logic             wr_pend;
    logic [IW-1:0]    out_r, out_c;
    logic [ACC_W-1:0] mac_acc;

    logic             in_fire, out_fire, in_illegal;
    logic             ld_first, ld_last, mac_en, mac_last, out_last_w;
    logic [W-1:0]     in_elem;

    assign in_illegal = 32'(bus.in_data) > MAX_U;
    assign in_elem    = in_illegal ? '0 : bus.in_data;
    assign in_fire    = (state_q == LOAD) && bus.in_valid && ena;
    assign out_fire   = (state_q == DRAIN) && bus.out_ready && ena;

    assign ld_first   = !ld_b && (ld_r == '0) && (ld_c == '0);
    assign ld_last    = ld_b && (ld_r == LAST) && (ld_c == LAST);
    assign mac_en     = ena && (state_q == COMPUTE);
    assign mac_last   = (ci == LAST) && (cj == LAST) && (ck == LAST);
    assign out_last_w = (out_r == LAST) && (out_c == LAST);

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_last  = (state_q == DRAIN) && out_last_w;
    assign bus.out_data  = ((state_q == DRAIN) && !error) ? c_mem[out_r][out_c] : '0;
    assign busy          = (state_q != LOAD);

    matmul_mac #(
        .N (N),
        .W (W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .ena   (mac_en),
        .clr   (ck == '0),
        .a     (a_mem[ci][ck]),
        .b     (b_mem[ck][cj]),
        .acc   (mac_acc)
    );

    // State register; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && ld_last)     state_d = COMPUTE;
            COMPUTE: if (mac_en && mac_last)     state_d = DRAIN;
            DRAIN:   if (out_fire && out_last_w) state_d = LOAD;
            default:                             state_d = LOAD;
        endcase
    end

    // Load position (row, column, A/B select) and the per-pair sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_r  <= '0;
            ld_c  <= '0;
            ld_b  <= 1'b0;
            error <= 1'b0;
        end else if (in_fire) begin
            error <= ld_first ? in_illegal : (error | in_illegal);
            if (ld_c == LAST) begin
                ld_c <= '0;
                if (ld_r == LAST) begin
                    ld_r <= '0;
                    ld_b <= !ld_b;
                end else begin
                    ld_r <= ld_r + 1'b1;
                end
            end else begin
                ld_c <= ld_c + 1'b1;
            end
        end
    end

    // i/j/k sweep, k innermost. The MAC output is registered, so each finished
    // sum is written into C one enabled cycle after its k==N-1 step.
    always_ff @(posedge clk) begin
        if (reset) begin
            ci      <= '0;
            cj      <= '0;
            ck      <= '0;
            wr_i    <= '0;
            wr_j    <= '0;
            wr_pend <= 1'b0;
        end else if (ena) begin
            wr_pend <= mac_en && (ck == LAST);
            if (mac_en && (ck == LAST)) begin
                wr_i <= ci;
                wr_j <= cj;
            end
            if (mac_en) begin
                if (ck == LAST) begin
                    ck <= '0;
                    if (cj == LAST) begin
                        cj <= '0;
                        ci <= (ci == LAST) ? '0 : ci + 1'b1;
                    end else begin
                        cj <= cj + 1'b1;
                    end
                end else begin
                    ck <= ck + 1'b1;
                end
            end
        end
    end

    // Matrix storage; not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && in_fire) begin
            if (ld_b) b_mem[ld_r][ld_c] <= in_elem;
            else      a_mem[ld_r][ld_c] <= in_elem;
        end
        if (!reset && ena && wr_pend) begin
            c_mem[wr_i][wr_j] <= mac_acc;
        end
    end

    // Output position; advances only on an accepted output.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= '0;
            out_c <= '0;
        end else if (out_fire) begin
            if (out_c == LAST) begin
                out_c <= '0;
                out_r <= (out_r == LAST) ? '0 : out_r + 1'b1;
            end else begin
                out_c <= out_c + 1'b1;
            end
        end
    end

endmodule
